// File: rtl/input_vc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : input_vc_unit
//  Function : Per-input-port flit buffer and packet sequencer for one virtual
//             channel. Buffers incoming flits in a FIFO, requests an output VC
//             for each packet head, then requests the switch flit-by-flit
//             while downstream credits are available.
//  Options  : INPUT_VC_ERR_CHK_EN - when defined, err is a sticky flag set by
//             a push dropped on a full FIFO or by a non-HEAD flit discarded
//             while idle. When undefined, err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module input_vc_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int OUT_CREDITS = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] in_flit_data,
    input  logic [1:0]            in_flit_type,
    input  logic                  in_valid,
    output logic                  credit_out,
    output logic                  vc_req,
    input  logic                  vc_grant,
    output logic                  sw_req,
    input  logic                  sw_grant,
    output logic [DATA_WIDTH-1:0] out_flit_data,
    output logic [1:0]            out_flit_type,
    output logic                  out_flit_fire,
    input  logic                  credit_in,
    output logic                  err
);

    // Flit type encodings shared with the rest of the router. Only HEAD and
    // TAIL need decoding here; BODY (2'b10) and the unused code 2'b00 are
    // both simply "not HEAD, not TAIL".
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = $clog2(OUT_CREDITS + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(OUT_CREDITS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_VC_WAIT = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH+1:0]   mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [CRD_W-1:0]        credit_cnt;

    logic                    not_empty;
    logic                    head_is_head;
    logic                    head_is_tail;
    logic                    discard;
    logic                    pop;
    logic                    push;

    // ------------------------------------------------------------------
    // Head-of-FIFO view and control decode
    // ------------------------------------------------------------------
    assign not_empty                      = (count != '0);
    assign {out_flit_type, out_flit_data} = mem[rd_ptr];
    assign head_is_head                   = (out_flit_type == FLIT_HEAD);
    assign head_is_tail                   = (out_flit_type == FLIT_TAIL);

    // A stray non-HEAD flit at the head while idle can never be routed, so
    // it is dropped to keep the FIFO from deadlocking behind it.
    assign discard       = (state == ST_IDLE) && not_empty && !head_is_head;

    assign vc_req        = (state == ST_VC_WAIT);
    assign sw_req        = (state == ST_ACTIVE) && not_empty && (credit_cnt != '0);
    assign out_flit_fire = sw_req && sw_grant;

    assign pop           = out_flit_fire || discard;
    // A full FIFO can still accept a flit in a cycle where one leaves.
    assign push          = in_valid && ((count != FULL_CNT) || pop);

    // FIFO storage write; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_flit_type, in_flit_data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Packet sequencer: wait for a head, win an output VC, stream to the tail
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (not_empty && head_is_head) begin
                        state <= ST_VC_WAIT;
                    end
                end
                ST_VC_WAIT: begin
                    if (vc_grant) begin
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (out_flit_fire && head_is_tail) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Downstream credit counter; saturates at the downstream buffer depth
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credit_cnt <= CRD_MAX;
        end else begin
            if (out_flit_fire && !credit_in) begin
                credit_cnt <= credit_cnt - CRD_W'(1);
            end else if (credit_in && !out_flit_fire && (credit_cnt != CRD_MAX)) begin
                credit_cnt <= credit_cnt + CRD_W'(1);
            end
        end
    end

    // Upstream credit return: one pulse per freed slot, including discards
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credit_out <= 1'b0;
        end else begin
            credit_out <= pop;
        end
    end

`ifdef INPUT_VC_ERR_CHK_EN
    logic drop;
    assign drop = in_valid && !push;

    // Sticky protocol error: overflow drop or stray non-HEAD flit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if (drop || discard) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_vc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_vc_unit
//  Function : Self-checking bench for input_vc_unit. A queue-based reference
//             model predicts every output each cycle; directed scenarios and
//             a randomized traffic run compare the DUT against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_input_vc_unit;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int OUTC  = 4;

    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] BODY = 2'b10;
    localparam logic [1:0] TAIL = 2'b11;

    localparam int P_IDLE = 0;
    localparam int P_VCW  = 1;
    localparam int P_ACT  = 2;

`ifdef INPUT_VC_ERR_CHK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] in_flit_data = '0;
    logic [1:0]    in_flit_type = 2'b00;
    logic          in_valid = 1'b0;
    logic          credit_out;
    logic          vc_req;
    logic          vc_grant = 1'b0;
    logic          sw_req;
    logic          sw_grant = 1'b0;
    logic [DW-1:0] out_flit_data;
    logic [1:0]    out_flit_type;
    logic          out_flit_fire;
    logic          credit_in = 1'b0;
    logic          err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    input_vc_unit #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .OUT_CREDITS (OUTC)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_flit_data  (in_flit_data),
        .in_flit_type  (in_flit_type),
        .in_valid      (in_valid),
        .credit_out    (credit_out),
        .vc_req        (vc_req),
        .vc_grant      (vc_grant),
        .sw_req        (sw_req),
        .sw_grant      (sw_grant),
        .out_flit_data (out_flit_data),
        .out_flit_type (out_flit_type),
        .out_flit_fire (out_flit_fire),
        .credit_in     (credit_in),
        .err           (err)
    );

    // ---------------- reference model ----------------
    logic [DW+1:0] mq[$];
    int            m_phase;
    int            m_cred;
    bit            m_err;
    bit            m_prev_pop;

    int            n_phase;
    int            n_cred;
    bit            n_err;
    bit            n_pop;
    bit            n_push;
    logic [DW+1:0] n_word;

    bit            e_vc, e_sw, e_fire, e_cout, e_err, e_has;
    logic [1:0]    e_type;
    logic [DW-1:0] e_data;

    task automatic model_reset();
        mq.delete();
        m_phase = P_IDLE; m_cred = OUTC; m_err = 1'b0; m_prev_pop = 1'b0;
        n_phase = P_IDLE; n_cred = OUTC; n_err = 1'b0;
        n_pop = 1'b0; n_push = 1'b0; n_word = '0;
    endtask

    task automatic model_commit();
        if (n_pop)  void'(mq.pop_front());
        if (n_push) mq.push_back(n_word);
        m_phase    = n_phase;
        m_cred     = n_cred;
        m_err      = n_err;
        m_prev_pop = n_pop;
    endtask

    task automatic model_eval();
        bit         disc;
        logic [1:0] ht;
        e_has  = (mq.size() > 0);
        ht     = e_has ? mq[0][DW+1:DW] : 2'b00;
        e_type = ht;
        e_data = e_has ? mq[0][DW-1:0] : '0;
        e_vc   = (m_phase == P_VCW);
        e_sw   = (m_phase == P_ACT) && e_has && (m_cred > 0);
        e_fire = e_sw && sw_grant;
        e_cout = m_prev_pop;
        e_err  = m_err;
        disc   = (m_phase == P_IDLE) && e_has && (ht != HEAD);
        n_pop  = e_fire || disc;
        n_push = in_valid && ((mq.size() < DEPTH) || n_pop);
        n_word = {in_flit_type, in_flit_data};
        n_phase = m_phase;
        if (m_phase == P_IDLE && e_has && ht == HEAD) n_phase = P_VCW;
        else if (m_phase == P_VCW && vc_grant)        n_phase = P_ACT;
        else if (m_phase == P_ACT && e_fire && ht == TAIL) n_phase = P_IDLE;
        n_cred = m_cred;
        if (e_fire && !credit_in)                          n_cred = m_cred - 1;
        else if (credit_in && !e_fire && m_cred < OUTC)    n_cred = m_cred + 1;
        n_err = m_err;
        if (ERR_ON && ((in_valid && !n_push) || disc)) n_err = 1'b1;
    endtask

    // One cycle: advance the model past the last edge, drive inputs, predict.
    task automatic apply(input bit iv, input logic [1:0] ty, input logic [DW-1:0] d,
                         input bit vg, input bit sg, input bit ci);
        @(negedge clk);
        model_commit();
        in_valid = iv; in_flit_type = ty; in_flit_data = d;
        vc_grant = vg; sw_grant = sg; credit_in = ci;
        #1;
        model_eval();
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_flit_type = 2'b00; in_flit_data = '0;
        vc_grant = 1'b0; sw_grant = 1'b0; credit_in = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        total++; if (vc_req !== 1'b0)        begin bad++; $display("FAIL reset_vc_req got=%b exp=0", vc_req); end
        total++; if (sw_req !== 1'b0)        begin bad++; $display("FAIL reset_sw_req got=%b exp=0", sw_req); end
        total++; if (out_flit_fire !== 1'b0) begin bad++; $display("FAIL reset_fire got=%b exp=0", out_flit_fire); end
        total++; if (credit_out !== 1'b0)    begin bad++; $display("FAIL reset_credit_out got=%b exp=0", credit_out); end
        total++; if (err !== 1'b0)           begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic run_packet_hbt(input string tag);
        int         fires = 0, vcs = 0, couts = 0;
        logic [1:0] types[$];
        for (int c = 0; c < 10; c++) begin
            if (c < 3) apply(1'b1, (c == 0) ? HEAD : ((c == 1) ? BODY : TAIL), DW'(32'hA000 + c), 1'b1, 1'b1, 1'b0);
            else       apply(1'b0, 2'b00, '0, 1'b1, 1'b1, 1'b0);
            total++; if (out_flit_fire !== e_fire) begin bad++; $display("FAIL %s_fire c=%0d got=%b exp=%b", tag, c, out_flit_fire, e_fire); end
            total++; if (credit_out !== e_cout)    begin bad++; $display("FAIL %s_credit_out c=%0d got=%b exp=%b", tag, c, credit_out, e_cout); end
            if (out_flit_fire === 1'b1) begin fires++; types.push_back(out_flit_type); end
            if (vc_req === 1'b1) vcs++;
            if (credit_out === 1'b1) couts++;
        end
        total++; if (fires != 3) begin bad++; $display("FAIL %s_fire_count got=%0d exp=3", tag, fires); end
        total++; if (vcs != 1)   begin bad++; $display("FAIL %s_vc_req_cycles got=%0d exp=1", tag, vcs); end
        total++; if (couts != 3) begin bad++; $display("FAIL %s_credit_out_count got=%0d exp=3", tag, couts); end
        total++;
        if (types.size() != 3 || types[0] !== HEAD || types[1] !== BODY || types[2] !== TAIL) begin
            bad++; $display("FAIL %s_fire_types got_n=%0d exp=HEAD,BODY,TAIL", tag, types.size());
        end
        total++; if (vc_req !== 1'b0 || sw_req !== 1'b0) begin bad++; $display("FAIL %s_back_to_idle vc=%b sw=%b exp=0,0", tag, vc_req, sw_req); end
    endtask

    task automatic test_basic_packet();
        do_reset();
        run_packet_hbt("basic");
    endtask

    task automatic test_credit_limit();
        int fires = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c < 6) apply(1'b1, (c == 0) ? HEAD : ((c == 5) ? TAIL : BODY), DW'(c), 1'b1, 1'b1, 1'b0);
            else       apply(1'b0, 2'b00, '0, 1'b1, 1'b1, 1'b0);
            total++; if (out_flit_fire !== e_fire) begin bad++; $display("FAIL credit_fire c=%0d got=%b exp=%b", c, out_flit_fire, e_fire); end
            if (out_flit_fire === 1'b1) fires++;
        end
        total++; if (fires != OUTC) begin bad++; $display("FAIL credit_fires_before_stall got=%0d exp=%0d", fires, OUTC); end
        total++; if (sw_req !== 1'b0) begin bad++; $display("FAIL credit_stall_sw_req got=%b exp=0", sw_req); end
        fires = 0;
        for (int c = 0; c < 6; c++) begin
            apply(1'b0, 2'b00, '0, 1'b1, 1'b1, (c == 0));
            total++; if (sw_req !== e_sw) begin bad++; $display("FAIL credit_sw_req c=%0d got=%b exp=%b", c, sw_req, e_sw); end
            if (out_flit_fire === 1'b1) fires++;
        end
        total++; if (fires != 1) begin bad++; $display("FAIL credit_one_return_fires got=%0d exp=1", fires); end
    endtask

    task automatic test_fire_and_credit_same_cycle();
        int fires = 0;
        do_reset();
        // Third fire lands in cycle 5 with credit_cnt at 2; credit_in there
        // must leave it at 2, allowing exactly two further fires.
        for (int c = 0; c < 14; c++) begin
            if (c < 6) apply(1'b1, (c == 0) ? HEAD : ((c == 5) ? TAIL : BODY), DW'(c), 1'b1, 1'b1, (c == 5));
            else       apply(1'b0, 2'b00, '0, 1'b1, 1'b1, 1'b0);
            total++; if (out_flit_fire !== e_fire) begin bad++; $display("FAIL samecyc_fire c=%0d got=%b exp=%b", c, out_flit_fire, e_fire); end
            if (out_flit_fire === 1'b1) fires++;
        end
        total++; if (fires != 5) begin bad++; $display("FAIL samecyc_total_fires got=%0d exp=5", fires); end
    endtask

    task automatic test_overflow_and_full_passthrough();
        logic [DW-1:0] seen[$];
        logic [DW-1:0] want[6];
        want[0] = 1; want[1] = 2; want[2] = 3; want[3] = 4; want[4] = 6; want[5] = 7;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            case (c)
                0: apply(1'b1, HEAD, 1, 1'b0, 1'b0, 1'b0);
                1: apply(1'b1, BODY, 2, 1'b0, 1'b0, 1'b0);
                2: apply(1'b1, BODY, 3, 1'b0, 1'b0, 1'b0);
                3: apply(1'b1, BODY, 4, 1'b0, 1'b0, 1'b0);
                4: apply(1'b1, TAIL, 5, 1'b0, 1'b0, 1'b0);
                5: apply(1'b0, 2'b00, 0, 1'b1, 1'b0, 1'b0);
                6: apply(1'b1, BODY, 6, 1'b0, 1'b1, 1'b1);
                7: apply(1'b1, TAIL, 7, 1'b0, 1'b1, 1'b1);
                default: apply(1'b0, 2'b00, 0, 1'b0, 1'b1, 1'b1);
            endcase
            if (c == 5) begin
                total++; if (err !== ERR_ON) begin bad++; $display("FAIL overflow_err got=%b exp=%b", err, ERR_ON); end
            end
            if (c == 6) begin
                total++; if (out_flit_fire !== 1'b1) begin bad++; $display("FAIL full_pushpop_fire got=%b exp=1", out_flit_fire); end
            end
            total++; if (out_flit_fire !== e_fire) begin bad++; $display("FAIL overflow_fire c=%0d got=%b exp=%b", c, out_flit_fire, e_fire); end
            if (out_flit_fire === 1'b1) seen.push_back(out_flit_data);
        end
        total++;
        if (seen.size() != 6) begin
            bad++; $display("FAIL overflow_flit_count got=%0d exp=6", seen.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (seen[i] !== want[i]) begin
                    bad++; $display("FAIL overflow_order idx=%0d got=%0d exp=%0d", i, seen[i], want[i]);
                    break;
                end
            end
        end
        total++; if (vc_req !== 1'b0 || sw_req !== 1'b0) begin bad++; $display("FAIL overflow_idle vc=%b sw=%b exp=0,0", vc_req, sw_req); end
    endtask

    task automatic test_discard();
        do_reset();
        apply(1'b1, BODY, 32'hBAD, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 2'b00, '0, 1'b1, 1'b1, 1'b0);
        total++; if (vc_req !== 1'b0)        begin bad++; $display("FAIL discard_vc_req got=%b exp=0", vc_req); end
        total++; if (out_flit_fire !== 1'b0) begin bad++; $display("FAIL discard_fire got=%b exp=0", out_flit_fire); end
        apply(1'b0, 2'b00, '0, 1'b1, 1'b1, 1'b0);
        total++; if (credit_out !== 1'b1)    begin bad++; $display("FAIL discard_credit_out got=%b exp=1", credit_out); end
        total++; if (err !== ERR_ON)         begin bad++; $display("FAIL discard_err got=%b exp=%b", err, ERR_ON); end
        apply(1'b0, 2'b00, '0, 1'b1, 1'b1, 1'b0);
        total++; if (credit_out !== 1'b0 || vc_req !== 1'b0) begin bad++; $display("FAIL discard_after cout=%b vc=%b exp=0,0", credit_out, vc_req); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        apply(1'b1, HEAD, 32'h11, 1'b1, 1'b1, 1'b0);
        apply(1'b1, BODY, 32'h22, 1'b1, 1'b1, 1'b0);
        apply(1'b1, BODY, 32'h33, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 2'b00, '0, 1'b1, 1'b1, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        total++; if (vc_req !== 1'b0 || sw_req !== 1'b0 || out_flit_fire !== 1'b0) begin
            bad++; $display("FAIL midreset_req vc=%b sw=%b fire=%b exp=0,0,0", vc_req, sw_req, out_flit_fire);
        end
        total++; if (credit_out !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL midreset_flags cout=%b err=%b exp=0,0", credit_out, err);
        end
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        run_packet_hbt("post_reset");
    endtask

    task automatic test_random();
        int         left = 0;
        bit         iv, vg, sg, ci;
        logic [1:0] ty;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            iv = ($urandom_range(0, 3) != 0);
            ty = 2'b00;
            if (iv) begin
                if (left == 0) begin
                    if ($urandom_range(0, 15) == 0) ty = BODY;
                    else begin ty = HEAD; left = $urandom_range(1, 4); end
                end else begin
                    ty = (left == 1) ? TAIL : BODY;
                    left--;
                end
            end
            vg = ($urandom_range(0, 1) == 1);
            sg = ($urandom_range(0, 3) != 0);
            ci = ($urandom_range(0, 2) == 0);
            apply(iv, ty, DW'($urandom), vg, sg, ci);
            total++; if (vc_req !== e_vc)        begin bad++; $display("FAIL rand_vc_req c=%0d got=%b exp=%b", c, vc_req, e_vc); end
            total++; if (sw_req !== e_sw)        begin bad++; $display("FAIL rand_sw_req c=%0d got=%b exp=%b", c, sw_req, e_sw); end
            total++; if (out_flit_fire !== e_fire) begin bad++; $display("FAIL rand_fire c=%0d got=%b exp=%b", c, out_flit_fire, e_fire); end
            total++; if (credit_out !== e_cout)  begin bad++; $display("FAIL rand_credit_out c=%0d got=%b exp=%b", c, credit_out, e_cout); end
            total++; if (err !== e_err)          begin bad++; $display("FAIL rand_err c=%0d got=%b exp=%b", c, err, e_err); end
            if (e_has) begin
                total++;
                if (out_flit_type !== e_type || out_flit_data !== e_data) begin
                    bad++; $display("FAIL rand_head c=%0d got=%0d/%h exp=%0d/%h", c, out_flit_type, out_flit_data, e_type, e_data);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_packet();
        test_credit_limit();
        test_fire_and_credit_same_cycle();
        test_overflow_and_full_passthrough();
        test_discard();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
